// File: rtl/ysyx_220066_pkg.sv
// Shared constants and state encoding for the ysyx_220066 instruction fetch unit.
package ysyx_220066_pkg;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

  typedef enum logic [2:0] {
    IFU_IDLE  = 3'd0,
    IFU_REQ   = 3'd1,
    IFU_WAIT  = 3'd2,
    IFU_VALID = 3'd3,
    IFU_EXEC  = 3'd4
  } ifu_state_e;

endpackage

// File: rtl/ysyx_220066_ifu_if.sv
// Fetch-side buses: instruction memory request/response and the decode handshake.
interface ysyx_220066_ifu_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_addr;
  logic        imem_resp_valid;
  logic [63:0] imem_resp_data;
  logic        imem_resp_err;

  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_fault;

  modport master (
    output imem_req_valid, imem_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
    output inst_valid, inst, inst_pc, inst_fault,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
    input  inst_valid, inst, inst_pc, inst_fault,
    output inst_ready
  );

endinterface

// File: rtl/ysyx_220066_inst_align.sv
// Combinational word select from a fetched doubleword, with misalignment and
// access-fault detection; any fault replaces the instruction with a NOP.
module ysyx_220066_inst_align
  import ysyx_220066_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic [2:0]  pc_lo,
  input  logic [63:0] resp_data,
  input  logic        resp_err,
  output logic        misaligned,
  output logic [31:0] inst,
  output logic        fault
);

  logic [31:0] word;

  always_comb begin
    misaligned = |pc_lo[1:0];
    word       = pc_lo[2] ? resp_data[63:32] : resp_data[31:0];
    fault      = misaligned | resp_err;
    inst       = fault ? NOP_INST : word;
  end

endmodule

// File: rtl/ysyx_220066_ifu.sv
// Instruction fetch unit: one outstanding doubleword fetch per retired PC.
//   state | meaning
//   IDLE  | one cycle after reset release
//   REQ   | request presented (or misaligned PC, skip memory)
//   WAIT  | request accepted, waiting for response
//   VALID | instruction held for decode
//   EXEC  | decode took it, waiting for pc_update
module ysyx_220066_ifu
  import ysyx_220066_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [63:0]               nxtpc,
  input  logic                      pc_update,
  ysyx_220066_ifu_if.master         bus
);

  ifu_state_e  state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [63:0] inst_pc_q, inst_pc_d;
  logic        inst_fault_q, inst_fault_d;

  logic        misaligned;
  logic [31:0] align_inst;
  logic        align_fault;
  logic        capture;
  logic        load_pc;

  ysyx_220066_inst_align #(
    .NOP_INST (NOP_INST)
  ) u_align (
    .pc_lo      (pc_q[2:0]),
    .resp_data  (bus.imem_resp_data),
    .resp_err   (bus.imem_resp_err),
    .misaligned (misaligned),
    .inst       (align_inst),
    .fault      (align_fault)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IFU_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IFU_IDLE:  state_d = IFU_REQ;
      IFU_REQ: begin
        if (misaligned)              state_d = IFU_VALID;
        else if (bus.imem_req_ready) state_d = IFU_WAIT;
      end
      IFU_WAIT: begin
        if (bus.imem_resp_valid) state_d = IFU_VALID;
      end
      IFU_VALID: begin
        if (bus.inst_ready) state_d = pc_update ? IFU_REQ : IFU_EXEC;
      end
      IFU_EXEC: begin
        if (pc_update) state_d = IFU_REQ;
      end
      default:   state_d = IFU_IDLE;
    endcase
  end

  always_comb begin
    bus.imem_req_valid = (state_q == IFU_REQ) && !misaligned;
    bus.imem_addr      = {pc_q[63:3], 3'b000};
    bus.inst_valid     = (state_q == IFU_VALID);
    bus.inst           = inst_q;
    bus.inst_pc        = inst_pc_q;
    bus.inst_fault     = inst_fault_q;
  end

  // Results come only from registers, so imem_resp_* never reaches inst* combinationally.
  always_comb begin
    capture = ((state_q == IFU_REQ) && misaligned) ||
              ((state_q == IFU_WAIT) && bus.imem_resp_valid);
    load_pc = pc_update &&
              ((state_q == IFU_EXEC) || ((state_q == IFU_VALID) && bus.inst_ready));

    pc_d         = load_pc ? nxtpc : pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_fault_d = inst_fault_q;
    if (capture) begin
      inst_d       = align_inst;
      inst_pc_d    = pc_q;
      inst_fault_d = align_fault;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_fault_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_fault_q <= inst_fault_d;
    end
  end

endmodule

// File: tb/tb_ysyx_220066_ifu.sv
// Directed bench for the fetch unit: inputs driven and outputs sampled on the falling edge.
module tb_ysyx_220066_ifu;

  logic        clk;
  logic        rst_n;
  logic [63:0] nxtpc;
  logic        pc_update;
  int          checks;
  int          errors;

  ysyx_220066_ifu_if bus ();

  ysyx_220066_ifu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .nxtpc     (nxtpc),
    .pc_update (pc_update),
    .bus       (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  localparam logic [63:0] D1 = 64'h00100093_00000013;

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    nxtpc = '0;
    pc_update = 1'b0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.imem_resp_err   = 1'b0;
    bus.inst_ready      = 1'b0;

    @(negedge clk);
    @(negedge clk);
    chk("rst_req_valid",  {63'd0, bus.imem_req_valid}, 64'd0);
    chk("rst_inst_valid", {63'd0, bus.inst_valid}, 64'd0);
    chk("rst_inst",       {32'd0, bus.inst}, 64'd0);
    chk("rst_inst_pc",    bus.inst_pc, 64'd0);
    chk("rst_fault",      {63'd0, bus.inst_fault}, 64'd0);
    chk("rst_addr",       bus.imem_addr, 64'h8000_0000);

    // First fetch after reset release
    rst_n = 1'b1;
    chk("idle_no_req", {63'd0, bus.imem_req_valid}, 64'd0);
    tick();
    chk("req1_valid", {63'd0, bus.imem_req_valid}, 64'd1);
    chk("req1_addr",  bus.imem_addr, 64'h8000_0000);
    bus.imem_req_ready = 1'b1;
    tick();
    chk("wait1_no_req", {63'd0, bus.imem_req_valid}, 64'd0);
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = D1;
    chk("wait1_no_inst", {63'd0, bus.inst_valid}, 64'd0);
    tick();
    bus.imem_resp_valid = 1'b0;
    chk("f1_valid", {63'd0, bus.inst_valid}, 64'd1);
    chk("f1_inst",  {32'd0, bus.inst}, 64'h0000_0013);
    chk("f1_pc",    bus.inst_pc, 64'h8000_0000);
    chk("f1_fault", {63'd0, bus.inst_fault}, 64'd0);

    // Handshake with same-cycle pc_update goes straight to REQ
    bus.inst_ready = 1'b1;
    pc_update = 1'b1;
    nxtpc = 64'h8000_0004;
    tick();
    bus.inst_ready = 1'b0;
    pc_update = 1'b0;
    chk("f2_inst_valid_low", {63'd0, bus.inst_valid}, 64'd0);
    chk("f2_req_valid",      {63'd0, bus.imem_req_valid}, 64'd1);
    chk("f2_addr",           bus.imem_addr, 64'h8000_0000);
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = D1;
    tick();
    bus.imem_resp_valid = 1'b0;
    chk("f2_inst",  {32'd0, bus.inst}, 64'h0010_0093);
    chk("f2_pc",    bus.inst_pc, 64'h8000_0004);

    // Handshake without pc_update parks in EXEC
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    chk("exec_inst_valid", {63'd0, bus.inst_valid}, 64'd0);
    chk("exec_no_req",     {63'd0, bus.imem_req_valid}, 64'd0);
    tick();
    chk("exec_hold_no_req", {63'd0, bus.imem_req_valid}, 64'd0);

    // Back-pressure on the request, with a stray response that must be ignored
    pc_update = 1'b1;
    nxtpc = 64'h8000_0008;
    tick();
    pc_update = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 64'hbad0bad0_bad0bad0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_req_valid", {63'd0, bus.imem_req_valid}, 64'd1);
      chk("stall_addr",      bus.imem_addr, 64'h8000_0008);
      tick();
    end
    chk("stall_end_req_valid", {63'd0, bus.imem_req_valid}, 64'd1);
    chk("stall_end_inst_valid", {63'd0, bus.inst_valid}, 64'd0);
    bus.imem_resp_valid = 1'b0;
    bus.imem_req_ready  = 1'b1;
    tick();
    chk("accept_once", {63'd0, bus.imem_req_valid}, 64'd0);
    pc_update = 1'b1;
    nxtpc = 64'h9000_0000;
    tick();
    pc_update = 1'b0;
    chk("wait_upd_no_req",   {63'd0, bus.imem_req_valid}, 64'd0);
    chk("wait_upd_no_valid", {63'd0, bus.inst_valid}, 64'd0);
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 64'h11111111_cafef00d;
    tick();
    bus.imem_resp_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("hold_valid",  {63'd0, bus.inst_valid}, 64'd1);
      chk("hold_inst",   {32'd0, bus.inst}, 64'h0000_0000_cafe_f00d);
      chk("hold_pc",     bus.inst_pc, 64'h8000_0008);
      chk("hold_fault",  {63'd0, bus.inst_fault}, 64'd0);
      chk("hold_no_req", {63'd0, bus.imem_req_valid}, 64'd0);
      tick();
    end

    // Misaligned PC skips memory
    bus.inst_ready = 1'b1;
    pc_update = 1'b1;
    nxtpc = 64'h8000_0002;
    tick();
    bus.inst_ready = 1'b0;
    pc_update = 1'b0;
    bus.imem_req_ready = 1'b1;
    chk("mis_no_req",   {63'd0, bus.imem_req_valid}, 64'd0);
    chk("mis_no_valid", {63'd0, bus.inst_valid}, 64'd0);
    tick();
    bus.imem_req_ready = 1'b0;
    chk("mis_valid", {63'd0, bus.inst_valid}, 64'd1);
    chk("mis_fault", {63'd0, bus.inst_fault}, 64'd1);
    chk("mis_inst",  {32'd0, bus.inst}, 64'h0000_0013);
    chk("mis_pc",    bus.inst_pc, 64'h8000_0002);

    // Access fault on the response
    bus.inst_ready = 1'b1;
    pc_update = 1'b1;
    nxtpc = 64'h8000_0014;
    tick();
    bus.inst_ready = 1'b0;
    pc_update = 1'b0;
    chk("err_req_valid", {63'd0, bus.imem_req_valid}, 64'd1);
    chk("err_addr",      bus.imem_addr, 64'h8000_0010);
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_err   = 1'b1;
    bus.imem_resp_data  = 64'h00200093_00300093;
    tick();
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_err   = 1'b0;
    chk("err_inst",  {32'd0, bus.inst}, 64'h0000_0013);
    chk("err_fault", {63'd0, bus.inst_fault}, 64'd1);
    chk("err_pc",    bus.inst_pc, 64'h8000_0014);

    // Reset while a request is outstanding
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    pc_update = 1'b1;
    nxtpc = 64'h8000_0020;
    tick();
    pc_update = 1'b0;
    chk("r2_addr", bus.imem_addr, 64'h8000_0020);
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("r2_req_valid",  {63'd0, bus.imem_req_valid}, 64'd0);
    chk("r2_inst_valid", {63'd0, bus.inst_valid}, 64'd0);
    chk("r2_inst",       {32'd0, bus.inst}, 64'd0);
    chk("r2_inst_pc",    bus.inst_pc, 64'd0);
    chk("r2_fault",      {63'd0, bus.inst_fault}, 64'd0);
    chk("r2_rst_addr",   bus.imem_addr, 64'h8000_0000);
    @(negedge clk);
    rst_n = 1'b1;
    chk("r2_idle_no_req", {63'd0, bus.imem_req_valid}, 64'd0);
    tick();
    chk("r2_refetch_valid", {63'd0, bus.imem_req_valid}, 64'd1);
    chk("r2_refetch_addr",  bus.imem_addr, 64'h8000_0000);
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = D1;
    tick();
    bus.imem_resp_valid = 1'b0;
    chk("r2_f_valid", {63'd0, bus.inst_valid}, 64'd1);
    chk("r2_f_inst",  {32'd0, bus.inst}, 64'h0000_0013);
    chk("r2_f_pc",    bus.inst_pc, 64'h8000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_220066_ifu.md
YSYX_220066_IFU -- requirements
Module: ysyx_220066_ifu

Interface
REQ-001 Parameter RESET_PC SHALL be 64-bit, default 64'h0000_0000_8000_0000, and SHALL give the first fetch address after reset.
REQ-002 Parameter NOP_INST SHALL be 32-bit, default 32'h0000_0013, and SHALL be the instruction presented on a fault.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 nxtpc  in  64  next PC from the nxtPC stage.
REQ-006 pc_update  in  1  current instruction retired; load nxtpc.
REQ-007 imem_req_valid  out  1  fetch request valid.
REQ-008 imem_req_ready  in  1  memory accepts request.
REQ-009 imem_addr  out  64  doubleword-aligned fetch address {pc[63:3],3'b000}.
REQ-010 imem_resp_valid  in  1  read data valid.
REQ-011 imem_resp_data  in  64  read doubleword.
REQ-012 imem_resp_err  in  1  access fault, qualified by imem_resp_valid.
REQ-013 inst_valid  out  1  instruction valid to decode.
REQ-014 inst_ready  in  1  decode accepts instruction.
REQ-015 inst  out  32  fetched instruction.
REQ-016 inst_pc  out  64  PC of inst.
REQ-017 inst_fault  out  1  misaligned PC or access fault; inst equals NOP_INST.

Function
REQ-018 The FSM SHALL have the states IDLE, REQ, WAIT, VALID and EXEC.
REQ-019 IDLE SHALL last exactly one cycle after reset release and then go to REQ.
REQ-020 In REQ, imem_req_valid SHALL be 1; on imem_req_valid && imem_req_ready the FSM SHALL go to WAIT; imem_addr SHALL stay stable while unaccepted.
REQ-021 At most one request SHALL be outstanding.
REQ-022 imem_resp_valid SHALL be sampled only in WAIT and ignored in every other state.
REQ-023 On a response in WAIT, the IFU SHALL register inst (imem_resp_data[63:32] if pc[2]=1, else [31:0]), inst_pc=pc and inst_fault=imem_resp_err, then go to VALID.
REQ-024 inst_valid SHALL assert the cycle after the response cycle (minimum fetch latency: REQ accept cycle + 1 response cycle + 1).
REQ-025 In VALID, inst, inst_pc and inst_fault SHALL hold stable until inst_valid && inst_ready.
REQ-026 On that handshake the FSM SHALL go to EXEC, unless pc_update is 1 in the same cycle, in which case it SHALL go directly to REQ.
REQ-027 In EXEC, inst_valid SHALL be 0; on pc_update the IFU SHALL load pc<=nxtpc and go to REQ.
REQ-028 pc_update SHALL be ignored outside EXEC and the VALID handshake cycle.
REQ-029 If the loaded PC has pc[1:0]!=0, the IFU SHALL issue no memory request and SHALL go to VALID the next cycle with inst=NOP_INST and inst_fault=1.
REQ-030 On imem_resp_err, inst SHALL be NOP_INST.
REQ-031 PC arithmetic SHALL be 64-bit wrap-around; the IFU performs no increment itself, because nxtpc is authoritative.

Reset
REQ-032 On rst_n=0, asynchronously: pc=RESET_PC, state=IDLE, imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0, inst_fault=0.
REQ-033 Reset asserted in WAIT SHALL abandon the request; the memory shares rst_n, so no stale response follows.

Structure
REQ-034 Shared package ysyx_220066_pkg SHALL hold RESET_PC default, NOP_INST, and the IFU state encoding (3-bit).
REQ-035 Sub-module ysyx_220066_inst_align SHALL be combinational and SHALL perform word select, misalignment detection and the NOP substitution.
REQ-036 The IFU SHALL have no combinational path from imem_resp_* to inst*.

Verification
REQ-037 Reset release with imem_req_ready=1 and response one cycle after acceptance, data 64'h00100093_00000013 -> imem_addr=0x80000000; inst=32'h00000013, inst_pc=0x80000000 valid 2 cycles after accept.
REQ-038 Handshake with pc_update=1 and nxtpc=0x80000004 in the same cycle -> next request address 0x80000000; inst=32'h00100093, inst_pc=0x80000004.
REQ-039 imem_req_ready held 0 for 5 cycles -> imem_req_valid=1 and imem_addr unchanged throughout; exactly one accept.
REQ-040 nxtpc=0x80000002 -> no imem_req_valid; next cycle inst_valid=1, inst_fault=1, inst=0x00000013.
REQ-041 inst_ready=0 for 4 cycles in VALID, and pc_update pulsed in WAIT -> outputs stable, pc_update ignored, no new request.
REQ-042 rst_n asserted mid-WAIT, then released -> all outputs at reset values, refetch from 0x80000000.
